serv_dbus_seq: RTL and testbench

Data-bus sequencer between the core's load/store datapath and a Wishbone-style data bus. It takes one load or store request, checks alignment, and runs one bus cycle with byte selects. It returns the read word and load strobe directly to the buffer register (`i_dat`/`i_load`) together with the latched byte offset used for lane selection (`i_lsb`). It also provides a bus-error path and a timeout.

---
 rtl/serv_dbus_seq.sv | 150 +++++++++++++++
 tb/tb_serv_dbus_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serv_dbus_seq.sv
// Data-bus sequencer: turns one aligned load/store request into a single
// Wishbone cycle and reports completion, misalignment, bus error or timeout.
module serv_dbus_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  output logic        o_ack,
  output logic        o_load,
  output logic [31:0] o_rdat,
  output logic [1:0]  o_lsb,
  output logic        o_misalign,
  output logic        o_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic [1:0]  o_state_dbg
);
  // Handshake: i_req is a level sampled only in IDLE; o_ack pulses for one
  // cycle per access, the core drops i_req the cycle after o_ack, and any
  // i_req seen high in IDLE starts a new access.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          ack_q, load_q, err_q, mis_q, cyc_q, we_q;
  logic [31:0]   rdat_q, adr_q, dat_q;
  logic [1:0]    lsb_q;
  logic [3:0]    sel_q;

  logic [3:0]    sel_d;
  logic          misalign_d;
  logic          timeout_d;

  always_comb begin
    sel_d      = 4'b1111;
    misalign_d = 1'b0;
    case (i_size)
      2'b00: sel_d = 4'b0001 << i_adr[1:0];
      2'b01: begin
        sel_d      = i_adr[1] ? 4'b1100 : 4'b0011;
        misalign_d = i_adr[0];
      end
      default: misalign_d = |i_adr[1:0];
    endcase
  end

  // Counter reaches TO_LAST on the TIMEOUT-th cycle with cyc high.
  assign timeout_d = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      lsb_q   <= '0;
      sel_q   <= '0;
    end else begin
      ack_q  <= 1'b0;
      load_q <= 1'b0;
      err_q  <= 1'b0;
      mis_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req) begin
            lsb_q <= i_adr[1:0];
            if (misalign_d) begin
              ack_q   <= 1'b1;
              mis_q   <= 1'b1;
              state_q <= FAULT;
            end else begin
              we_q    <= i_we;
              adr_q   <= {i_adr[31:2], 2'b00};
              sel_q   <= sel_d;
              dat_q   <= i_wdat;
              cyc_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= BUS;
            end
          end
        end
        BUS: begin
          cnt_q <= cnt_q + CW'(1);
          if (i_wb_err || i_wb_ack || timeout_d) begin
            cyc_q   <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= RESP;
            // Error beats ack; ack beats a coincident timeout.
            if (i_wb_err) begin
              err_q <= 1'b1;
            end else if (i_wb_ack) begin
              load_q <= !we_q;
              if (!we_q) rdat_q <= i_wb_rdt;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RESP: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ack       = ack_q;
  assign o_load      = load_q;
  assign o_err       = err_q;
  assign o_misalign  = mis_q;
  assign o_rdat      = rdat_q;
  assign o_lsb       = lsb_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = cyc_q;
  assign o_wb_we     = we_q;
  assign o_wb_adr    = adr_q;
  assign o_wb_sel    = sel_q;
  assign o_wb_dat    = dat_q;
  assign o_state_dbg = state_q;

endmodule

// File: tb/tb_serv_dbus_seq.sv
// Directed bench for serv_dbus_seq (TIMEOUT=4) with hand-computed expectations.
module tb_serv_dbus_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, i_we = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic [31:0] i_adr = '0, i_wdat = '0, i_wb_rdt = '0;
  logic        i_wb_ack = 1'b0, i_wb_err = 1'b0;
  logic        o_ack, o_load, o_misalign, o_err, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_rdat, o_wb_adr, o_wb_dat;
  logic [1:0]  o_lsb, o_state_dbg;
  logic [3:0]  o_wb_sel;

  serv_dbus_seq #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_adr(i_adr), .i_wdat(i_wdat), .o_ack(o_ack), .o_load(o_load),
    .o_rdat(o_rdat), .o_lsb(o_lsb), .o_misalign(o_misalign), .o_err(o_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_state_dbg(o_state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_pulses = 0;
  logic [31:0] exp_q[$];

  // Observations of the most recent access
  int          n_cyc, lat;
  logic        r_load, r_err, r_mis, r_we, r_stb;
  logic [31:0] r_adr, r_dat;
  logic [3:0]  r_sel;
  logic [1:0]  r_lsb, r_state;

  always @(negedge clk) if (o_ack) ack_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request in the current cycle; respond on the resp_at-th cycle
  // with cyc high (-1 = never). Returns at the cycle o_ack is seen.
  task automatic access(input logic we, input logic [1:0] size, input logic [31:0] adr,
                        input logic [31:0] wdat, input int resp_at, input logic give_ack,
                        input logic give_err, input logic [31:0] rdt);
    i_req = 1'b1; i_we = we; i_size = size; i_adr = adr; i_wdat = wdat;
    n_cyc = 0; lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      step();
      i_req = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
      if (o_ack) begin
        lat = c; r_load = o_load; r_err = o_err; r_mis = o_misalign;
        r_lsb = o_lsb; r_state = o_state_dbg;
        check("cyc_low_at_ack", o_wb_cyc, 0);
        if (o_load) begin
          if (exp_q.size() > 0) check("rdat", o_rdat, exp_q.pop_front());
          else check("unexpected_load", o_load, 0);
        end
      end else if (o_wb_cyc) begin
        if (n_cyc == 0) begin
          r_adr = o_wb_adr; r_sel = o_wb_sel; r_we = o_wb_we; r_dat = o_wb_dat; r_stb = o_wb_stb;
        end
        if (n_cyc == resp_at) begin
          i_wb_ack = give_ack; i_wb_err = give_err; i_wb_rdt = rdt;
        end
        n_cyc++;
      end
    end
    if (lat < 0) check("ack_never_seen", 0, 1);
  endtask

  // One cycle after o_ack: pulse must be gone.
  task automatic after_ack();
    step();
    check("ack_width", o_ack, 0);
    check("load_width", o_load, 0);
    check("err_width", o_err, 0);
    check("mis_width", o_misalign, 0);
  endtask

  int saved_pulses;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_ack", o_ack, 0);
    check("rst_rdat", o_rdat, 0);
    check("rst_state", o_state_dbg, 0);
    rst = 1'b0;
    step();
    check("idle_cyc", o_wb_cyc, 0);
    check("idle_adr", o_wb_adr, 0);

    // Word load at 0x1000, ack on 4th cyc cycle (coincides with timeout count)
    exp_q.push_back(32'hDEADBEEF);
    access(1'b0, 2'b10, 32'h0000_1000, 32'h0, 3, 1'b1, 1'b0, 32'hDEADBEEF);
    check("wl_adr", r_adr, 32'h0000_1000);
    check("wl_sel", r_sel, 4'b1111);
    check("wl_we", r_we, 0);
    check("wl_stb", r_stb, 1);
    check("wl_ncyc", n_cyc, 4);
    check("wl_lat", lat, 5);
    check("wl_load", r_load, 1);
    check("wl_err", r_err, 0);
    check("wl_lsb", r_lsb, 0);
    check("wl_state", r_state, 2);
    after_ack();

    // Byte store at 0x2003, immediate ack
    access(1'b1, 2'b00, 32'h0000_2003, 32'hAB00_0000, 0, 1'b1, 1'b0, 32'h5555_5555);
    check("bs_adr", r_adr, 32'h0000_2000);
    check("bs_sel", r_sel, 4'b1000);
    check("bs_dat", r_dat, 32'hAB00_0000);
    check("bs_we", r_we, 1);
    check("bs_lat", lat, 2);
    check("bs_load", r_load, 0);
    check("bs_lsb", r_lsb, 3);
    check("bs_rdat_kept", o_rdat, 32'hDEADBEEF);
    after_ack();

    // Misaligned half at 0x3001
    access(1'b0, 2'b01, 32'h0000_3001, 32'h0, 0, 1'b1, 1'b0, 32'h0);
    check("mh_lat", lat, 1);
    check("mh_ncyc", n_cyc, 0);
    check("mh_mis", r_mis, 1);
    check("mh_load", r_load, 0);
    check("mh_lsb", r_lsb, 1);
    check("mh_state", r_state, 3);
    after_ack();

    // Misaligned word at 0x3002
    access(1'b0, 2'b11, 32'h0000_3002, 32'h0, 0, 1'b1, 1'b0, 32'h0);
    check("mw_lat", lat, 1);
    check("mw_ncyc", n_cyc, 0);
    check("mw_mis", r_mis, 1);
    check("mw_lsb", r_lsb, 2);
    after_ack();

    // Aligned half load at 0x3002
    exp_q.push_back(32'h1122_3344);
    access(1'b0, 2'b01, 32'h0000_3002, 32'h0, 0, 1'b1, 1'b0, 32'h1122_3344);
    check("hl_sel", r_sel, 4'b1100);
    check("hl_adr", r_adr, 32'h0000_3000);
    check("hl_mis", r_mis, 0);
    check("hl_load", r_load, 1);
    check("hl_lsb", r_lsb, 2);
    after_ack();

    // Timeout: no response
    access(1'b0, 2'b10, 32'h0000_6004, 32'h0, -1, 1'b0, 1'b0, 32'h0);
    check("to_ncyc", n_cyc, 4);
    check("to_lat", lat, 5);
    check("to_err", r_err, 1);
    check("to_load", r_load, 0);
    check("to_rdat_kept", o_rdat, 32'h1122_3344);
    after_ack();

    // Ack and err together: err wins, rdat untouched
    access(1'b0, 2'b10, 32'h0000_7008, 32'h0, 1, 1'b1, 1'b1, 32'h1234_5678);
    check("ae_err", r_err, 1);
    check("ae_load", r_load, 0);
    check("ae_ncyc", n_cyc, 2);
    check("ae_rdat_kept", o_rdat, 32'h1122_3344);
    after_ack();

    // Reset mid-BUS
    saved_pulses = ack_pulses;
    i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_adr = 32'h0000_5000;
    step();
    i_req = 1'b0;
    check("rb_cyc_before", o_wb_cyc, 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("rb_cyc", o_wb_cyc, 0);
    check("rb_stb", o_wb_stb, 0);
    check("rb_adr", o_wb_adr, 0);
    check("rb_sel", o_wb_sel, 0);
    check("rb_rdat", o_rdat, 0);
    check("rb_state", o_state_dbg, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check("rb_no_ack", ack_pulses, saved_pulses);

    // Fresh word load after reset
    exp_q.push_back(32'hCAFE_F00D);
    access(1'b0, 2'b10, 32'h0000_4004, 32'h0, 1, 1'b1, 1'b0, 32'hCAFE_F00D);
    check("fl_lat", lat, 3);
    check("fl_load", r_load, 1);
    check("fl_adr", r_adr, 32'h0000_4004);
    after_ack();

    // Back-to-back load then store, i_req low one cycle after each ack
    saved_pulses = ack_pulses;
    exp_q.push_back(32'h0BAD_F00D);
    access(1'b0, 2'b00, 32'h0000_8001, 32'h0, 0, 1'b1, 1'b0, 32'h0BAD_F00D);
    check("b1_sel", r_sel, 4'b0010);
    check("b1_we", r_we, 0);
    check("b1_load", r_load, 1);
    after_ack();
    access(1'b1, 2'b01, 32'h0000_8002, 32'h1234_0000, 0, 1'b1, 1'b0, 32'h0);
    check("b2_sel", r_sel, 4'b1100);
    check("b2_we", r_we, 1);
    check("b2_dat", r_dat, 32'h1234_0000);
    check("b2_load", r_load, 0);
    check("b2_rdat_kept", o_rdat, 32'h0BAD_F00D);
    after_ack();
    step();
    check("b2b_pulses", ack_pulses - saved_pulses, 2);
    check("total_pulses", ack_pulses, 10);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
